// File: rtl/int_ctl_pkg.sv
// rtl/int_ctl_pkg.sv - shared major-cycle/phase codes and opcodes for the interrupt controller
// Contents: F/D/E/H phase codes carried on the 5-bit state bus, the JMS 0 opcode,
// and a helper that recognises the halt (H) phases.
package int_ctl_pkg;

  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] D0 = 5'd4;
  localparam logic [4:0] D1 = 5'd5;
  localparam logic [4:0] D2 = 5'd6;
  localparam logic [4:0] D3 = 5'd7;
  localparam logic [4:0] E0 = 5'd8;
  localparam logic [4:0] E1 = 5'd9;
  localparam logic [4:0] E2 = 5'd10;
  localparam logic [4:0] E3 = 5'd11;
  localparam logic [4:0] H0 = 5'd12;
  localparam logic [4:0] H1 = 5'd13;
  localparam logic [4:0] H2 = 5'd14;
  localparam logic [4:0] H3 = 5'd15;

  // Instruction forced into IR when an interrupt is taken
  localparam logic [11:0] JMS_0 = 12'o4000;

  function automatic logic is_h_phase(input logic [4:0] s);
    return (s >= H0) && (s <= H3);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - NDEV-wide, SYNC_STAGES-deep synchronizer bank for device requests
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; clears every stage
//   d     - asynchronous device request lines
//   q     - synchronized request lines (last stage)
module irq_sync #(
  parameter int NDEV        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NDEV-1:0] d,
  output logic [NDEV-1:0] q
);
  import int_ctl_pkg::*;

  logic [NDEV-1:0] stg_q [SYNC_STAGES];
  logic [NDEV-1:0] stg_d [SYNC_STAGES];

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctl.sv
// rtl/int_ctl.sv - interrupt request/grant controller feeding the interrupt-enable block
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   clear            - synchronous clear, same effect as reset
//   state            - major-cycle/phase code (F0..H3)
//   instr_end        - strobe in the final phase of every instruction
//   run              - processor running
//   dev_irq          - asynchronous level-sensitive device requests
//   ui, int_ena, int_inh - user-interrupt flag, enable and inhibit from downstream
//   mask_wr, mask_din    - device mask load strobe and value
//   irq              - combined masked request
//   int_in_prog      - interrupt sequence in progress
//   force_jms        - IR must load JMS 0 instead of memory data
//   irq_status       - {ui, pad, masked synchronized requests}
//   int_count        - number of interrupts taken (wraps)
module int_ctl
  import int_ctl_pkg::*;
#(
  parameter int          NDEV        = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] MASK_RST    = 12'o7777
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [4:0]      state,
  input  logic            instr_end,
  input  logic            run,
  input  logic [NDEV-1:0] dev_irq,
  input  logic            ui,
  input  logic            int_ena,
  input  logic            int_inh,
  input  logic            mask_wr,
  input  logic [11:0]     mask_din,
  output logic            irq,
  output logic            int_in_prog,
  output logic            force_jms,
  output logic [11:0]     irq_status,
  output logic [11:0]     int_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    RUNJ = 2'd2
  } fsm_t;

  logic rst;
  assign rst = reset | clear;

  logic [NDEV-1:0] sync_vec;

  irq_sync #(
    .NDEV        (NDEV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .reset (rst),
    .d     (dev_irq),
    .q     (sync_vec)
  );

  logic [11:0] mask_q, mask_d;
  logic [11:0] req_full;
  logic [11:0] status_q, status_d;
  logic        irq_q, irq_d;
  logic [11:0] count_q, count_d;
  fsm_t        fsm_q, fsm_d;

  // Full 12-bit mask is kept; bits at or above NDEV meet zero-extended sync bits.
  always_comb begin
    mask_d = mask_q;
    if (mask_wr) begin
      mask_d = mask_din;
    end
    req_full     = 12'(sync_vec) & mask_q;
    irq_d        = (|req_full) | ui;
    status_d     = req_full;
    status_d[11] = ui;
  end

  // Entry is only from IDLE; once taken the sequence ignores irq, run and instr_end
  // and leaves only on the forced instruction's F3/E3 or an H-phase abort.
  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    case (fsm_q)
      IDLE: begin
        if (instr_end && run && int_ena && !int_inh && irq_q) begin
          fsm_d   = TAKE;
          count_d = count_q + 12'd1;
        end
      end
      TAKE: begin
        if (is_h_phase(state)) begin
          fsm_d = IDLE;
        end else if (state == F3) begin
          fsm_d = RUNJ;
        end
      end
      RUNJ: begin
        if (is_h_phase(state) || (state == E3)) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= MASK_RST;
      irq_q    <= 1'b0;
      status_q <= 12'd0;
      count_q  <= 12'd0;
      fsm_q    <= IDLE;
    end else begin
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      status_q <= status_d;
      count_q  <= count_d;
      fsm_q    <= fsm_d;
    end
  end

  assign irq         = irq_q;
  assign irq_status  = status_q;
  assign int_count   = count_q;
  assign int_in_prog = (fsm_q != IDLE);
  assign force_jms   = (fsm_q == TAKE);

endmodule

// File: tb/tb_int_ctl.sv
// tb/tb_int_ctl.sv - self-checking bench for int_ctl
module tb_int_ctl;
  import int_ctl_pkg::*;

  localparam int          NDEV = 8;
  localparam int          S    = 2;
  localparam logic [11:0] MRST = 12'o7777;

  logic            clk = 1'b0;
  logic            reset, clear, instr_end, run, ui, int_ena, int_inh, mask_wr;
  logic [4:0]      state;
  logic [NDEV-1:0] dev_irq;
  logic [11:0]     mask_din;
  logic            irq, int_in_prog, force_jms;
  logic [11:0]     irq_status, int_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NDEV-1:0] hist [$];
  logic [11:0]     mask_m, cnt_m, stat_m;
  logic            irq_m, busy_m, fetch_m;

  always #5 clk = ~clk;

  int_ctl #(
    .NDEV        (NDEV),
    .SYNC_STAGES (S),
    .MASK_RST    (MRST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .state       (state),
    .instr_end   (instr_end),
    .run         (run),
    .dev_irq     (dev_irq),
    .ui          (ui),
    .int_ena     (int_ena),
    .int_inh     (int_inh),
    .mask_wr     (mask_wr),
    .mask_din    (mask_din),
    .irq         (irq),
    .int_in_prog (int_in_prog),
    .force_jms   (force_jms),
    .irq_status  (irq_status),
    .int_count   (int_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the model consumes the inputs of the cycle that just ended,
  // then every output is compared 1 time unit after the edge.
  task automatic tick();
    logic            took;
    logic [NDEV-1:0] req;
    @(posedge clk);
    #1;
    if (reset || clear) begin
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back('0);
      mask_m  = MRST;
      irq_m   = 1'b0;
      stat_m  = 12'd0;
      cnt_m   = 12'd0;
      busy_m  = 1'b0;
      fetch_m = 1'b0;
    end else begin
      took = instr_end && run && int_ena && !int_inh && irq_m && !busy_m;
      if (busy_m && is_h_phase(state)) begin
        busy_m  = 1'b0;
        fetch_m = 1'b0;
      end else if (busy_m && fetch_m && state == F3) begin
        fetch_m = 1'b0;
      end else if (busy_m && !fetch_m && state == E3) begin
        busy_m = 1'b0;
      end else if (took) begin
        busy_m  = 1'b1;
        fetch_m = 1'b1;
        cnt_m   = cnt_m + 12'd1;
      end
      hist.push_back(dev_irq);
      void'(hist.pop_front());
      req    = hist[0] & mask_m[NDEV-1:0];
      irq_m  = (|req) | ui;
      stat_m = {ui, 3'b000, req};
      if (mask_wr) mask_m = mask_din;
    end
    check("irq", 32'(irq), 32'(irq_m));
    check("irq_status", 32'(irq_status), 32'(stat_m));
    check("int_count", 32'(int_count), 32'(cnt_m));
    check("int_in_prog", 32'(int_in_prog), 32'(busy_m));
    check("force_jms", 32'(force_jms), 32'(fetch_m));
  endtask

  // Present one phase for one clock; downstream drops int_ena at the forced E0.
  task automatic drive_phase(input logic [4:0] p, input logic ie);
    state     = p;
    instr_end = ie;
    tick();
    mask_wr   = 1'b0;
    instr_end = 1'b0;
    if (busy_m && !fetch_m && p == E0) int_ena = 1'b0;
  endtask

  task automatic instr(input logic exec);
    drive_phase(F0, 1'b0);
    drive_phase(F1, 1'b0);
    drive_phase(F2, 1'b0);
    drive_phase(F3, !exec);
    if (exec) begin
      drive_phase(E0, 1'b0);
      drive_phase(E1, 1'b0);
      drive_phase(E2, 1'b0);
      drive_phase(E3, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; instr_end = 1'b0; run = 1'b0; ui = 1'b0;
    int_ena = 1'b0; int_inh = 1'b0; state = D0; dev_irq = '0;
    mask_din = 12'd0; mask_wr = 1'b1;        // must be ignored under reset
    tick();
    tick();
    reset = 1'b0; mask_wr = 1'b0;
    drive_phase(D0, 1'b0);
    check("rst_count", 32'(int_count), 32'd0);
    check("rst_status", 32'(irq_status), 32'd0);

    // Device 3 through the synchronizer: irq after three clocks
    dev_irq = 8'h08;
    drive_phase(D0, 1'b0);
    drive_phase(D0, 1'b0);
    check("irq_lat2", 32'(irq), 32'd0);
    drive_phase(D0, 1'b0);
    check("irq_lat3", 32'(irq), 32'd1);
    check("status_0010", 32'(irq_status), 32'o0010);

    // int_ena low blocks the take
    run = 1'b1;
    instr(1'b0);
    check("ena_blocks", 32'(int_in_prog), 32'd0);

    // Take at instruction end; run and irq fall during the sequence
    int_ena = 1'b1;
    instr(1'b0);
    check("take_fj", 32'(force_jms), 32'd1);
    check("take_iip", 32'(int_in_prog), 32'd1);
    run = 1'b0; dev_irq = '0;
    instr(1'b1);
    check("seq_done_iip", 32'(int_in_prog), 32'd0);
    check("seq_count1", 32'(int_count), 32'd1);
    run = 1'b1;

    // Inhibit blocks, then clearing it lets the next boundary take
    dev_irq = 8'h08; int_ena = 1'b1; int_inh = 1'b1;
    instr(1'b0);
    check("inh_blocks", 32'(int_in_prog), 32'd0);
    int_inh = 1'b0;
    instr(1'b0);
    check("retake_after_inh", 32'(int_in_prog), 32'd1);
    instr(1'b1);
    check("seq_count2", 32'(int_count), 32'd2);

    // Mask out device 3, then raise ui
    mask_din = 12'o7767; mask_wr = 1'b1;
    drive_phase(D0, 1'b0);
    drive_phase(D0, 1'b0);
    check("mask_irq0", 32'(irq), 32'd0);
    ui = 1'b1;
    drive_phase(D0, 1'b0);
    check("ui_irq", 32'(irq), 32'd1);
    check("ui_status11", 32'(irq_status[11]), 32'd1);

    // H-phase abort keeps the count; clear mid-sequence zeroes it
    int_ena = 1'b1;
    instr(1'b0);
    drive_phase(F0, 1'b0);
    drive_phase(F1, 1'b0);
    drive_phase(H1, 1'b0);
    check("abort_iip", 32'(int_in_prog), 32'd0);
    check("abort_count", 32'(int_count), 32'd3);
    instr(1'b0);
    drive_phase(F0, 1'b0);
    clear = 1'b1;
    drive_phase(F1, 1'b0);
    clear = 1'b0;
    check("clear_count", 32'(int_count), 32'd0);
    check("clear_iip", 32'(int_in_prog), 32'd0);
    check("clear_fj", 32'(force_jms), 32'd0);

    // Count wrap: take + H-abort pairs
    drive_phase(D0, 1'b0);
    for (int i = 0; i < 4095; i++) begin
      drive_phase(F3, 1'b1);
      drive_phase(H0, 1'b0);
    end
    check("count_7777", 32'(int_count), 32'o7777);
    drive_phase(F3, 1'b1);
    check("count_wrap", 32'(int_count), 32'd0);
    drive_phase(H0, 1'b0);

    // Randomized instruction stream against the model
    ui = 1'b0; int_ena = 1'b0;
    for (int i = 0; i < 300; i++) begin
      dev_irq = NDEV'($urandom);
      ui      = ($urandom_range(0, 7) == 0);
      int_inh = ($urandom_range(0, 3) == 0);
      run     = ($urandom_range(0, 7) != 0);
      if (!busy_m && $urandom_range(0, 1) == 1) int_ena = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        mask_din = 12'($urandom);
        mask_wr  = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) drive_phase(H2, 1'b0);
      instr(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctl.md
Name: int_ctl

Overview:
- Interrupt request/grant controller sitting directly upstream of the memory-extension/interrupt-enable block.
- Synchronizes and masks device interrupt lines and merges the user-interrupt flag into the `irq` line consumed downstream.
- At an instruction boundary it decides whether to take an interrupt, then drives `int_in_prog` and `force_jms` for the forced JMS 0 instruction.
- Consumes `int_ena` and `int_inh` back from the downstream block.

Parameters:
- NDEV, 8, number of device interrupt request lines (1..12).
- SYNC_STAGES, 2, synchronizer depth for device lines (2 or 3).
- MASK_RST, all ones, reset/clear value of the device mask register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear (CAF / front-panel clear); same effect as reset
- state  in  5  major-cycle/phase code (F0..F3, D0..D3, E0..E3, H0..H3 from the shared parameters include)
- instr_end  in  1  one-clock strobe from the sequencer in the final phase of every instruction
- run  in  1  processor running; 0 = halted/panel mode
- dev_irq  in  NDEV  asynchronous, level-sensitive device requests
- ui  in  1  user-interrupt flag (UI) from the downstream block
- int_ena  in  1  interrupt enable from the downstream block
- int_inh  in  1  interrupt inhibit (CIF pending) from the downstream block
- mask_wr  in  1  one-clock strobe: load the device mask register
- mask_din  in  12  mask value; bit i enables dev_irq[i]; bits >= NDEV ignored
- irq  out  1  combined masked request to the downstream block
- int_in_prog  out  1  interrupt sequence in progress
- force_jms  out  1  instruction register must load 4000 (JMS 0) instead of memory data
- irq_status  out  12  synchronized masked request vector; bit 11 = ui
- int_count  out  12  count of interrupts taken

Behaviour:
- Reset or clear:
  - synchronizers = 0, mask = MASK_RST, FSM = IDLE, int_count = 0.
  - All outputs 0 except irq_status = 0.
- Synchronizer: each dev_irq bit passes through SYNC_STAGES flops. Latency from a line change to irq = SYNC_STAGES+1 clocks.
- Status and request logic:
  - `req_vec` = sync & mask[0:NDEV-1].
  - `irq_status` = {ui, zero pad, req_vec}, registered.
  - `irq` = |req_vec | ui, registered, 1-clock latency from sync output.
- Mask write: mask_wr loads mask_din at the next edge. The new mask affects irq one clock later. A mask_wr in the same cycle as reset/clear is ignored.
- FSM states: IDLE, TAKE, RUNJ.
  - IDLE -> TAKE when instr_end & run & int_ena & ~int_inh & irq. Otherwise stay in IDLE.
  - On entry to TAKE:
    - int_in_prog=1, force_jms=1.
    - int_count increments, wrapping 7777 -> 0000.
  - TAKE -> RUNJ when state==F3. force_jms drops on that transition, so it covers the full forced fetch F0..F3.
  - RUNJ -> IDLE on the clock after state==E3. int_in_prog drops then.
  - int_in_prog is therefore high across E0, where the downstream block saves UF/IF/DF and clears int_ena.
- Boundary conditions:
  - instr_end with irq=1 but int_ena=0 or int_inh=1: no take, stay IDLE.
  - irq drops while in TAKE/RUNJ: sequence completes anyway; requests are not re-sampled.
  - run falls while in TAKE/RUNJ: sequence continues; only entry from IDLE is gated by run.
  - state enters an H phase while in TAKE/RUNJ: abort to IDLE, clear int_in_prog and force_jms, do not undo int_count.
  - instr_end asserted while not in IDLE: ignored.
  - Reset or clear mid-sequence: immediate return to IDLE, outputs 0.
  - After RUNJ -> IDLE, no retake is possible until int_ena is re-set (ION delay is handled downstream).

Decomposition:
- State codes (F0..H3) and the JMS opcode 4000 stay in the shared parameters include.
- FSM encoding stays local to int_ctl.
- One natural sub-module: `irq_sync`, a parameterized NDEV × SYNC_STAGES synchronizer bank, instantiated once.

Test Plan:
- Reset, then dev_irq[3]=1, mask=7777 -> irq=1 after 3 clocks; irq_status=0010 (octal).
- int_ena=1, int_inh=0, irq=1, instr_end at F3 -> int_in_prog=1 and force_jms=1 next clock; force_jms drops after the next F3; int_in_prog drops after E3; int_count=1.
- Same as the previous case but int_inh=1 -> no take; clearing int_inh, then the next instr_end -> take occurs.
- mask_wr with 7767 while dev_irq[3]=1 -> irq=0 two clocks later; ui=1 -> irq=1, irq_status bit 11 set.
- Mid-sequence state=H1 -> FSM returns to IDLE, int_in_prog=0, int_count retained; repeat with clear=1 -> int_count=0.
- Force 4096 takes -> int_count wraps 7777 -> 0000.
